// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with exception entry/return and a
// double-fault halt.
//
// Parameters
//   RESET_PC  PC loaded by reset
//   EXC_PC    exception / fault vector
//   IM_AW     instruction-memory word-address width (2^IM_AW words)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous reset, active low
//   stall      hold PC (hazard)
//   br_taken   taken branch, target = br_pc4 + (signext(br_imm) << 2)
//   br_pc4     branch base address
//   br_imm     branch word offset
//   j_en       j/jal, target = {pc4[31:28], j_index, 2'b00}
//   j_index    jump index
//   jr_en      register jump to jr_target
//   jr_target  register jump target
//   exc_req    enter exception: pc <= EXC_PC, epc <= pc
//   eret       return from exception: pc <= epc
//   pc, pc4    current PC and PC + 4 (32-bit wrap)
//   im_addr    instruction-memory word address, relative to RESET_PC
//   epc        exception PC
//   addr_fault current PC is misaligned or outside instruction memory
//   redirect   one-cycle pulse after any non-sequential PC load
//   halted     high while in the double-fault HALT state
//   inst_cnt   count of cycles that issued an instruction
module pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter int          IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [31:0]      br_pc4,
   input  logic [15:0]      br_imm,
   input  logic             j_en,
   input  logic [25:0]      j_index,
   input  logic             jr_en,
   input  logic [31:0]      jr_target,
   input  logic             exc_req,
   input  logic             eret,
   output logic [31:0]      pc,
   output logic [31:0]      pc4,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      epc,
   output logic             addr_fault,
   output logic             redirect,
   output logic             halted,
   output logic [31:0]      inst_cnt
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cnt_q, cnt_d;
   logic        redir_q, redir_d;

   logic [31:0] pc_off;
   logic [31:0] br_target;
   logic [31:0] j_target;

   // Offset from the start of instruction memory; a PC below RESET_PC
   // wraps to a huge offset and so also reads as out of range.
   assign pc_off     = pc_q - RESET_PC;
   assign pc4        = pc_q + 32'd4;
   assign im_addr    = pc_off[IM_AW+1:2];
   assign addr_fault = (pc_q[1:0] != 2'b00) || ((pc_off >> 2) >= (32'd1 << IM_AW));

   assign br_target  = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
   assign j_target   = {pc4[31:28], j_index, 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         epc_q   <= 32'd0;
         cnt_q   <= 32'd0;
         redir_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
         redir_q <= redir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      cnt_d   = cnt_q;
      redir_d = 1'b0;
      unique case (state_q)
         RUN: begin
            if (addr_fault) begin
               // Faulting on the vector itself cannot be recovered.
               if (pc_q == EXC_PC) begin
                  state_d = HALT;
               end else begin
                  pc_d    = EXC_PC;
                  epc_d   = pc_q;
                  redir_d = 1'b1;
               end
            end else begin
               if (!stall) cnt_d = cnt_q + 32'd1;
               // exc_req and eret override stall; branch-type requests
               // are held upstream until stall drops.
               if (exc_req) begin
                  pc_d    = EXC_PC;
                  epc_d   = pc_q;
                  redir_d = 1'b1;
               end else if (eret) begin
                  pc_d    = epc_q;
                  redir_d = 1'b1;
               end else if (stall) begin
                  pc_d    = pc_q;
               end else if (jr_en) begin
                  pc_d    = jr_target;
                  redir_d = 1'b1;
               end else if (j_en) begin
                  pc_d    = j_target;
                  redir_d = 1'b1;
               end else if (br_taken) begin
                  pc_d    = br_target;
                  redir_d = 1'b1;
               end else begin
                  pc_d    = pc4;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = RUN;
      endcase
   end

   assign pc       = pc_q;
   assign epc      = epc_q;
   assign inst_cnt = cnt_q;
   assign redirect = redir_q;
   assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   localparam logic [31:0] RST = 32'h0000_3000;
   localparam logic [31:0] EXC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, br_taken, j_en, jr_en, exc_req, eret;
   logic [31:0] br_pc4, jr_target;
   logic [15:0] br_imm;
   logic [25:0] j_index;

   // dut: IM_AW=12 so the default vector 0x4180 lies inside memory
   logic [31:0] pc, pc4, epc, inst_cnt;
   logic [11:0] im_addr;
   logic        addr_fault, redirect, halted;
   // dutb: defaults (IM_AW=10), vector 0x4180 is outside memory
   logic [31:0] pc_b, pc4_b, epc_b, inst_cnt_b;
   logic [9:0]  im_addr_b;
   logic        addr_fault_b, redirect_b, halted_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_gen #(.IM_AW(12)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
      .br_pc4(br_pc4), .br_imm(br_imm), .j_en(j_en), .j_index(j_index),
      .jr_en(jr_en), .jr_target(jr_target), .exc_req(exc_req), .eret(eret),
      .pc(pc), .pc4(pc4), .im_addr(im_addr), .epc(epc), .addr_fault(addr_fault),
      .redirect(redirect), .halted(halted), .inst_cnt(inst_cnt));

   pc_gen dutb (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
      .br_pc4(br_pc4), .br_imm(br_imm), .j_en(j_en), .j_index(j_index),
      .jr_en(jr_en), .jr_target(jr_target), .exc_req(exc_req), .eret(eret),
      .pc(pc_b), .pc4(pc4_b), .im_addr(im_addr_b), .epc(epc_b), .addr_fault(addr_fault_b),
      .redirect(redirect_b), .halted(halted_b), .inst_cnt(inst_cnt_b));

   task automatic clr_in();
      stall = 0; br_taken = 0; j_en = 0; jr_en = 0; exc_req = 0; eret = 0;
      br_pc4 = 0; br_imm = 0; j_index = 0; jr_target = 0;
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr_in();
      reset = 0;
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_reset();
      clr_in();
      reset = 0;
      #7;
      checks++; if (pc !== RST)          begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RST); end
      checks++; if (epc !== 32'd0)       begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
      checks++; if (inst_cnt !== 32'd0)  begin failures++; $display("FAIL reset_cnt got=%h exp=0", inst_cnt); end
      checks++; if (redirect !== 1'b0)   begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
      checks++; if (halted !== 1'b0)     begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
      checks++; if (pc_b !== RST)        begin failures++; $display("FAIL reset_pc_b got=%h exp=%h", pc_b, RST); end
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_sequential();
      do_reset();
      checks++; if (pc !== RST || im_addr !== 12'd0) begin failures++; $display("FAIL seq_start pc=%h im=%0d exp pc=%h im=0", pc, im_addr, RST); end
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (pc !== RST + 32'(4*i) || im_addr !== 12'(i) || redirect !== 1'b0 || pc4 !== RST + 32'(4*i+4)) begin
            failures++;
            $display("FAIL seq_step%0d pc=%h im=%0d rd=%b pc4=%h exp pc=%h im=%0d rd=0", i, pc, im_addr, redirect, pc4, RST + 32'(4*i), i);
         end
      end
      checks++; if (inst_cnt !== 32'd4) begin failures++; $display("FAIL seq_cnt got=%0d exp=4", inst_cnt); end
   endtask

   task automatic test_branch();
      do_reset();
      step(); step();
      br_taken = 1; br_pc4 = 32'h300C; br_imm = 16'hFFFE;
      step();
      checks++; if (pc !== 32'h3004 || redirect !== 1'b1) begin failures++; $display("FAIL br_taken pc=%h rd=%b exp pc=00003004 rd=1", pc, redirect); end
      clr_in();
      step();
      checks++; if (pc !== 32'h3008 || redirect !== 1'b0) begin failures++; $display("FAIL br_after pc=%h rd=%b exp pc=00003008 rd=0", pc, redirect); end
      br_taken = 1; br_pc4 = 32'h300C; br_imm = 16'hFFFE; stall = 1;
      step();
      checks++; if (pc !== 32'h3008 || redirect !== 1'b0) begin failures++; $display("FAIL br_stall pc=%h rd=%b exp pc=00003008 rd=0", pc, redirect); end
      // forward branch, positive offset
      stall = 0; br_pc4 = 32'h300C; br_imm = 16'h0010;
      step();
      checks++; if (pc !== 32'h304C) begin failures++; $display("FAIL br_fwd pc=%h exp=0000304c", pc); end
      clr_in();
   endtask

   task automatic test_priority();
      do_reset();
      jr_en = 1; jr_target = 32'h3100; j_en = 1; j_index = 26'h0000C80; br_taken = 1; br_pc4 = 32'h3010; br_imm = 16'h0004;
      step();
      checks++; if (pc !== 32'h3100 || redirect !== 1'b1) begin failures++; $display("FAIL prio_jr pc=%h rd=%b exp pc=00003100 rd=1", pc, redirect); end
      jr_en = 0;
      step();
      checks++; if (pc !== 32'h3200) begin failures++; $display("FAIL prio_j pc=%h exp=00003200", pc); end
      j_en = 0; br_pc4 = 32'h3204;
      step();
      checks++; if (pc !== 32'h3214) begin failures++; $display("FAIL prio_br pc=%h exp=00003214", pc); end
      clr_in();
   endtask

   task automatic test_fault_eret();
      do_reset();
      jr_en = 1; jr_target = 32'h3002;
      step();
      clr_in();
      checks++; if (pc !== 32'h3002 || addr_fault !== 1'b1) begin failures++; $display("FAIL flt_detect pc=%h af=%b exp pc=00003002 af=1", pc, addr_fault); end
      step();
      checks++; if (pc !== EXC || epc !== 32'h3002 || addr_fault !== 1'b0 || redirect !== 1'b1) begin
         failures++; $display("FAIL flt_vector pc=%h epc=%h af=%b rd=%b exp pc=%h epc=00003002 af=0 rd=1", pc, epc, addr_fault, redirect, EXC);
      end
      eret = 1;
      step();
      eret = 0;
      checks++; if (pc !== 32'h3002 || addr_fault !== 1'b1) begin failures++; $display("FAIL flt_eret pc=%h af=%b exp pc=00003002 af=1", pc, addr_fault); end
      step();
      checks++; if (pc !== EXC || halted !== 1'b0) begin failures++; $display("FAIL flt_again pc=%h hl=%b exp pc=%h hl=0", pc, halted, EXC); end
   endtask

   task automatic test_range_halt();
      logic [31:0] cnt_h;
      do_reset();
      jr_en = 1; jr_target = 32'h3FFC;
      step();
      clr_in();
      checks++; if (pc_b !== 32'h3FFC || addr_fault_b !== 1'b0 || im_addr_b !== 10'h3FF) begin failures++; $display("FAIL rng_top pc=%h af=%b im=%h exp pc=00003ffc af=0 im=3ff", pc_b, addr_fault_b, im_addr_b); end
      step();
      checks++; if (pc_b !== 32'h4000 || addr_fault_b !== 1'b1) begin failures++; $display("FAIL rng_over pc=%h af=%b exp pc=00004000 af=1", pc_b, addr_fault_b); end
      step();
      checks++; if (pc_b !== EXC || epc_b !== 32'h4000 || halted_b !== 1'b0) begin failures++; $display("FAIL rng_vec pc=%h epc=%h hl=%b exp pc=%h epc=00004000 hl=0", pc_b, epc_b, halted_b, EXC); end
      eret = 1;
      step();
      cnt_h = inst_cnt_b;
      checks++; if (halted_b !== 1'b1 || pc_b !== EXC || epc_b !== 32'h4000) begin failures++; $display("FAIL rng_halt hl=%b pc=%h epc=%h exp hl=1 pc=%h epc=00004000", halted_b, pc_b, epc_b, EXC); end
      for (int i = 0; i < 6; i++) begin
         exc_req = 1'($urandom); eret = 1'($urandom); jr_en = 1'($urandom); jr_target = 32'h3000; stall = 1'($urandom);
         step();
         checks++;
         if (halted_b !== 1'b1 || pc_b !== EXC || epc_b !== 32'h4000 || inst_cnt_b !== cnt_h || redirect_b !== 1'b0) begin
            failures++; $display("FAIL halt_hold%0d hl=%b pc=%h epc=%h cnt=%0d rd=%b exp hl=1 pc=%h cnt=%0d rd=0", i, halted_b, pc_b, epc_b, inst_cnt_b, redirect_b, EXC, cnt_h);
         end
      end
      clr_in();
      #2 reset = 0;
      #1;
      checks++; if (pc_b !== RST || halted_b !== 1'b0 || epc_b !== 32'd0 || inst_cnt_b !== 32'd0) begin
         failures++; $display("FAIL halt_async_rst pc=%h hl=%b epc=%h cnt=%0d exp pc=%h hl=0 epc=0 cnt=0", pc_b, halted_b, epc_b, inst_cnt_b, RST);
      end
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_exc_stall();
      do_reset();
      step(); step(); step(); step();
      exc_req = 1; stall = 1;
      step();
      clr_in();
      checks++; if (pc !== EXC || epc !== 32'h3010 || redirect !== 1'b1) begin failures++; $display("FAIL exc_stall pc=%h epc=%h rd=%b exp pc=%h epc=00003010 rd=1", pc, epc, redirect, EXC); end
      // reset in the cycle redirect is high
      #2 reset = 0;
      #1;
      checks++; if (pc !== RST || redirect !== 1'b0 || epc !== 32'd0) begin failures++; $display("FAIL redir_async_rst pc=%h rd=%b epc=%h exp pc=%h rd=0 epc=0", pc, redirect, epc, RST); end
      @(negedge clk);
      reset = 1;
   endtask

   // Reference model for dut (IM_AW=12): architectural rules in plain arithmetic.
   function automatic bit m_fault(logic [31:0] p);
      return (p % 4 != 0) || (((p - RST) / 4) >= 4096);
   endfunction

   task automatic test_random();
      logic [31:0] m_pc, m_epc, m_cnt, m_next;
      logic        m_halt, m_rd;
      logic signed [31:0] boff;
      do_reset();
      m_pc = RST; m_epc = 0; m_cnt = 0; m_halt = 0; m_rd = 0;
      for (int c = 0; c < 600; c++) begin
         stall    = ($urandom_range(0, 3) == 0);
         exc_req  = ($urandom_range(0, 19) == 0);
         eret     = ($urandom_range(0, 14) == 0);
         jr_en    = ($urandom_range(0, 7) == 0);
         j_en     = ($urandom_range(0, 7) == 0);
         br_taken = ($urandom_range(0, 5) == 0);
         jr_target = 32'h3000 + 32'($urandom_range(0, 16'h4FFF));
         if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
         j_index  = 26'($urandom_range(12'hC00, 16'h1C3F));
         br_pc4   = 32'h3000 + 32'($urandom_range(0, 16'h3FFF) * 4);
         br_imm   = 16'($urandom);
         // model next state
         m_next = m_pc; m_rd = 0;
         if (!m_halt) begin
            if (m_fault(m_pc)) begin
               if (m_pc == EXC) m_halt = 1;
               else begin m_epc = m_pc; m_next = EXC; m_rd = 1; end
            end else begin
               if (!stall) m_cnt = m_cnt + 1;
               if (exc_req)       begin m_epc = m_pc; m_next = EXC; m_rd = 1; end
               else if (eret)     begin m_next = m_epc; m_rd = 1; end
               else if (stall)    m_next = m_pc;
               else if (jr_en)    begin m_next = jr_target; m_rd = 1; end
               else if (j_en)     begin m_next = ((m_pc + 4) & 32'hF000_0000) + 32'(j_index) * 4; m_rd = 1; end
               else if (br_taken) begin boff = 32'($signed(br_imm)); m_next = br_pc4 + 32'(boff * 4); m_rd = 1; end
               else               m_next = m_pc + 4;
            end
         end
         m_pc = m_next;
         step();
         checks++;
         if (pc !== m_pc || epc !== m_epc || inst_cnt !== m_cnt || redirect !== m_rd || halted !== m_halt) begin
            failures++;
            $display("FAIL rnd_state cyc=%0d pc=%h epc=%h cnt=%0d rd=%b hl=%b exp pc=%h epc=%h cnt=%0d rd=%b hl=%b",
                     c, pc, epc, inst_cnt, redirect, halted, m_pc, m_epc, m_cnt, m_rd, m_halt);
         end
         checks++;
         if (addr_fault !== m_fault(m_pc) || im_addr !== 12'((m_pc - RST) / 4) || pc4 !== m_pc + 4) begin
            failures++;
            $display("FAIL rnd_comb cyc=%0d af=%b im=%h pc4=%h exp af=%b im=%h pc4=%h",
                     c, addr_fault, im_addr, pc4, m_fault(m_pc), 12'((m_pc - RST) / 4), m_pc + 4);
         end
      end
      clr_in();
   endtask

   initial begin
      clr_in();
      reset = 0;
      test_reset();
      test_sequential();
      test_branch();
      test_priority();
      test_fault_eret();
      test_range_halt();
      test_exc_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00003000, PC value loaded on reset.
REQ-002 SHALL have parameter EXC_PC, default 32'h00004180, exception/fault vector.
REQ-003 SHALL have parameter IM_AW, default 10, instruction-memory word-address width (depth 2^IM_AW words).
REQ-004 SHALL have port clk input 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-low; one clock, no other clock or reset.
REQ-006 SHALL have port stall input 1: hold PC (hazard).
REQ-007 SHALL have ports br_taken input 1, br_pc4 input 32, br_imm input 16: taken branch; target = br_pc4 + (signext(br_imm) << 2).
REQ-008 SHALL have ports j_en input 1, j_index input 26: j/jal; target = {pc4[31:28], j_index, 2'b00}, where pc4 is this block's pc4 output.
REQ-009 SHALL have ports jr_en input 1, jr_target input 32: register jump.
REQ-010 SHALL have ports exc_req input 1, eret input 1: enter exception / return to epc.
REQ-011 SHALL have ports pc output 32, pc4 output 32 (pc+4, 32-bit wrap), im_addr output IM_AW.
REQ-012 SHALL have ports epc output 32, addr_fault output 1, redirect output 1, halted output 1, inst_cnt output 32.

Function
REQ-013 im_addr SHALL be bits [IM_AW+1:2] of (pc - RESET_PC), combinational.
REQ-014 addr_fault SHALL be combinational 1 when pc[1:0]!=0, or (pc - RESET_PC) >> 2 >= 2^IM_AW (32-bit subtraction, so pc < RESET_PC also faults).
REQ-015 FSM states SHALL be RUN and HALT; reset enters RUN.
REQ-016 In RUN, next PC SHALL be chosen in this priority order:
- addr_fault
- exc_req
- eret
- stall
- jr_en
- j_en
- br_taken
- sequential (pc4)
REQ-017 addr_fault in RUN with pc != EXC_PC SHALL load pc<=EXC_PC and epc<=pc.
REQ-018 addr_fault in RUN with pc == EXC_PC SHALL enter HALT (double fault); pc and epc hold.
REQ-019 exc_req (no fault) SHALL load pc<=EXC_PC, epc<=pc, regardless of stall.
REQ-020 eret (no fault/exc_req) SHALL load pc<=epc, regardless of stall.
REQ-021 stall SHALL hold pc, even when jr_en/j_en/br_taken are asserted; upstream holds those requests until stall drops.
REQ-022 jr_en, j_en and br_taken SHALL load their targets per REQ-007..009; no alignment check at load, faults are detected on the following cycle via addr_fault.
REQ-023 redirect SHALL be a registered 1-cycle pulse, high in the cycle after any non-sequential PC load (fault, exc, eret, jr, j, branch); low after stall or sequential.
REQ-024 inst_cnt SHALL increment by 1 (mod 2^32) on each cycle in RUN where stall is low and addr_fault is low.
REQ-025 In HALT: pc, epc and inst_cnt SHALL hold; redirect=0; halted=1; all inputs SHALL be ignored; exit only via reset.
REQ-026 halted SHALL be 1 exactly when state is HALT.
REQ-027 pc4 and the branch sum SHALL wrap modulo 2^32 with no overflow flag.

Reset
REQ-028 On reset low, asynchronously:
- pc=RESET_PC, epc=0, inst_cnt=0
- redirect=0, halted=0, state=RUN
REQ-029 Reset asserted mid-operation, including in HALT or during a redirect, SHALL abort all in-flight updates immediately.
REQ-030 First PC advance SHALL occur on the first rising edge with reset high.

Verification
REQ-031 Reset release, no stimulus, 4 edges -> pc 0x3000,0x3004,0x3008,0x300C,0x3010; im_addr 0..4; inst_cnt=4; redirect=0 throughout.
REQ-032 pc=0x3008, br_taken=1, br_pc4=0x300C, br_imm=16'hFFFE -> pc=0x3004 next cycle, redirect=1 for one cycle; same request with stall=1 -> pc holds 0x3008, redirect=0.
REQ-033 Same cycle: jr_en=1 (jr_target=0x3100), j_en=1 (j_index=0x0000C80), br_taken=1 -> pc=0x3100 (jr wins).
REQ-034 jr_target=0x3002 -> next cycle addr_fault=1 -> following cycle pc=0x4180, epc=0x3002; then eret -> pc=0x3002 -> fault again.
REQ-035 IM_AW=10, pc reaches 0x3FFC then sequential -> pc=0x4000, addr_fault=1, pc=0x4180 next; with EXC_PC=0x5000 (also out of range) -> HALT, halted=1, pc frozen 0x5000 until reset.
REQ-036 Assert exc_req and stall together at pc=0x3010 -> pc=0x4180, epc=0x3010; pulse reset low mid-cycle in HALT -> pc=0x3000, halted=0 immediately.
